irq_ctrl: RTL
=============

// Module: irq_ctrl
// PURPOSE
//  Machine-mode interrupt controller downstream of the timer block. Latches the
//  1-cycle timer_interrupt pulse and the ext_irq level into mip and masks them with
//  mie/mstatus.MIE. Requests a trap from the core pipeline and, on acceptance,
//  captures mepc/mcause and supplies the handler target. Restores state on mret.
// PARAMETERS
//  MTVEC_RESET   32'h0000_0000  reset value of mtvec
//  MIE_RESET     1'b0           reset value of mstatus.MIE
// PORTS
//  clk              in   1   system clock, all state on rising edge
//  rst              in   1   reset; asynchronous, active-low
//  timer_interrupt  in   1   1-cycle pulse from timer
//  ext_irq          in   1   external interrupt, level, already synchronised
//  csr_we           in   1   CSR write strobe
//  csr_addr         in   12  CSR address (both read and write)
//  csr_wdata        in   32  CSR write data
//  csr_rdata        out  32  CSR read data, combinational from csr_addr
//  pc_in            in   32  PC of instruction to resume, valid with irq_ack
//  irq_ack          in   1   core accepts trap at an instruction boundary
//  mret             in   1   core retires mret (1-cycle pulse)
//  irq_req          out  1   trap request to core, registered
//  trap_pc          out  32  handler address, valid while irq_req=1
//  epc_out          out  32  current mepc, used by core on mret
// BEHAVIOUR
//  CSRs: mstatus 0x300 (MIE b3, MPIE b7, other bits read 0), mie 0x304 (MTIE b7,
//   MEIE b11), mtvec 0x305, mepc 0x341 (b1:0 read 0), mcause 0x342, mip 0x344
//   (MTIP b7, MEIP b11). Unmapped addresses read 0, writes ignored.
//  Reset: mstatus.MIE=MIE_RESET, MPIE=0, mie=0, mip.MTIP=0, mtvec=MTVEC_RESET,
//   mepc=0, mcause=0, state=IDLE, irq_req=0.
//  MTIP: set on any edge with timer_interrupt=1 and sticky. Cleared by a CSR write
//   to mip with b7=0, or by acceptance of a timer trap. Set wins over clear in the
//   same cycle. MEIP = ext_irq, read-only; mip writes to b11 are ignored.
//  pend = mstatus.MIE & ((MEIP&MEIE) | (MTIP&MTIE)). External has priority (code 11)
//   over timer (code 7). code is re-evaluated each cycle while in REQ.
//  trap_pc: mtvec[1:0]==0 -> {mtvec[31:2],2'b00}; mtvec[1:0]==1 ->
//   {mtvec[31:2],2'b00} + 4*code, 32-bit wrap. Modes 2 and 3 behave as mode 0.
//  FSM IDLE/REQ/HANDLER:
//   IDLE: pend=1 -> REQ (irq_req=1 from the next cycle).
//   REQ: irq_req=1. irq_ack=1 -> mepc<=pc_in&~3, mcause<={1'b1,27'b0,code},
//    MPIE<=MIE, MIE<=0, MTIP cleared if code==7 -> HANDLER. Else pend=0 (mask
//    changed) -> IDLE with irq_req dropped the next cycle.
//   HANDLER: irq_req=0; nested interrupts are not taken. mret=1 -> MIE<=MPIE,
//    MPIE<=1 -> IDLE.
//  irq_ack outside REQ and mret outside HANDLER are ignored.
//  Latency: timer pulse at edge E -> MTIP=1 after E -> irq_req=1 after E+1.
//  irq_ack in the same cycle as a CSR write to mstatus/mepc/mcause: the trap
//   update wins and the CSR write is dropped. mret in the same cycle as a CSR
//   write to mstatus: the mret update wins.
//  CSR writes take effect at the next edge. csr_rdata reflects the current
//   register values.
//  rst asserted mid-operation: all state returns to reset values immediately;
//   irq_req drops asynchronously.
// TESTING
//  1 mie=0x80, MIE=1, mtvec=0x100, timer pulse at edge E -> irq_req=1 after E+1,
//    trap_pc=0x100; ack with pc_in=0x2004 -> mepc=0x2004, mcause=0x80000007,
//    MTIP=0, MIE=0, MPIE=1.
//  2 mtvec=0x101, ext_irq=1 and MTIP=1, both enabled -> trap_pc=0x12C, mcause
//    =0x8000000B after ack, MTIP still 1.
//  3 In HANDLER, timer pulse -> MTIP=1, irq_req stays 0; mret -> MIE=1, IDLE,
//    irq_req=1 two cycles later.
//  4 In REQ, CSR write mstatus=0 with no ack -> IDLE, irq_req=0 next cycle,
//    mepc unchanged.
//  5 mie=0, timer pulse -> mip reads 0x80, no request; write mip=0 in the same
//    cycle as a second pulse -> MTIP stays 1.
//  6 rst low during REQ -> irq_req=0 immediately, all CSRs at reset values,
//    mtvec=MTVEC_RESET.

Source files
------------

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: mip/mie/mstatus masking, trap request FSM, trap CSR capture and mret restore.
// irq_req is registered (pending -> request one edge later); the request holds until the core acks or the source is masked.
module irq_ctrl #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic        MIE_RESET   = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        timer_interrupt,
   input  logic        ext_irq,
   input  logic        csr_we,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   input  logic [31:0] pc_in,
   input  logic        irq_ack,
   input  logic        mret,
   output logic        irq_req,
   output logic [31:0] trap_pc,
   output logic [31:0] epc_out
);

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MIE     = 12'h304;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   localparam logic [11:0] A_MIP     = 12'h344;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HANDLER} state_t;

   state_t      state_q, state_d;
   logic        irq_req_q, irq_req_d;
   logic        mstatus_mie_q, mstatus_mie_d;
   logic        mstatus_mpie_q, mstatus_mpie_d;
   logic        mtie_q, mtie_d;
   logic        meie_q, meie_d;
   logic        mtip_q, mtip_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;

   logic        ext_pend, tmr_pend, pend;
   logic [3:0]  code;
   logic        trap_take, mret_take;
   logic        wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause, wr_mip;
   logic [31:0] tvec_base;

   assign ext_pend = ext_irq & meie_q;
   assign tmr_pend = mtip_q & mtie_q;
   assign pend     = mstatus_mie_q & (ext_pend | tmr_pend);
   assign code     = ext_pend ? 4'd11 : 4'd7;

   assign trap_take = (state_q == S_REQ) & irq_ack;
   assign mret_take = (state_q == S_HANDLER) & mret;

   assign wr_mstatus = csr_we & (csr_addr == A_MSTATUS);
   assign wr_mie     = csr_we & (csr_addr == A_MIE);
   assign wr_mtvec   = csr_we & (csr_addr == A_MTVEC);
   assign wr_mepc    = csr_we & (csr_addr == A_MEPC);
   assign wr_mcause  = csr_we & (csr_addr == A_MCAUSE);
   assign wr_mip     = csr_we & (csr_addr == A_MIP);

   // Vectored mode only for mtvec[1:0]==1; reserved modes fall back to direct.
   assign tvec_base = {mtvec_q[31:2], 2'b00};
   assign trap_pc   = (mtvec_q[1:0] == 2'b01) ? (tvec_base + {26'b0, code, 2'b00}) : tvec_base;
   assign irq_req   = irq_req_q;
   assign epc_out   = mepc_q;

   always_comb begin
      state_d        = state_q;
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mtie_d         = mtie_q;
      meie_d         = meie_q;
      mtip_d         = mtip_q;
      mtvec_d        = mtvec_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;

      case (state_q)
         S_IDLE:    if (pend) state_d = S_REQ;
         S_REQ: begin
            if (irq_ack)    state_d = S_HANDLER;
            else if (!pend) state_d = S_IDLE;
         end
         S_HANDLER: if (mret) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      // Trap entry and mret outrank a concurrent software write to the same CSRs.
      if (trap_take) begin
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (mret_take) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end else if (wr_mstatus) begin
         mstatus_mie_d  = csr_wdata[3];
         mstatus_mpie_d = csr_wdata[7];
      end

      if (wr_mie) begin
         mtie_d = csr_wdata[7];
         meie_d = csr_wdata[11];
      end

      if (wr_mtvec) mtvec_d = csr_wdata;

      if (trap_take)    mepc_d = pc_in & 32'hFFFF_FFFC;
      else if (wr_mepc) mepc_d = csr_wdata & 32'hFFFF_FFFC;

      if (trap_take)      mcause_d = {1'b1, 27'b0, code};
      else if (wr_mcause) mcause_d = csr_wdata;

      if (wr_mip && !csr_wdata[7])         mtip_d = 1'b0;
      if (trap_take && (code == 4'd7))     mtip_d = 1'b0;
      if (timer_interrupt)                 mtip_d = 1'b1;

      irq_req_d = (state_d == S_REQ);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         irq_req_q      <= 1'b0;
         mstatus_mie_q  <= MIE_RESET;
         mstatus_mpie_q <= 1'b0;
         mtie_q         <= 1'b0;
         meie_q         <= 1'b0;
         mtip_q         <= 1'b0;
         mtvec_q        <= MTVEC_RESET;
         mepc_q         <= 32'h0;
         mcause_q       <= 32'h0;
      end else begin
         state_q        <= state_d;
         irq_req_q      <= irq_req_d;
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mtie_q         <= mtie_d;
         meie_q         <= meie_d;
         mtip_q         <= mtip_d;
         mtvec_q        <= mtvec_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
      end
   end

   always_comb begin
      csr_rdata = 32'h0;
      case (csr_addr)
         A_MSTATUS: csr_rdata = {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
         A_MIE:     csr_rdata = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
         A_MTVEC:   csr_rdata = mtvec_q;
         A_MEPC:    csr_rdata = mepc_q;
         A_MCAUSE:  csr_rdata = mcause_q;
         A_MIP:     csr_rdata = {20'b0, ext_irq, 3'b0, mtip_q, 7'b0};
         default:   csr_rdata = 32'h0;
      endcase
   end

endmodule
